// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole round controller.
//   - round state encodings, kept as plain logic constants
//   - LFSR feedback taps and a single-step helper
//   - default board geometry (mole count, score width)
package whack_pkg;

  typedef logic [2:0] round_state_t;

  localparam round_state_t ST_IDLE  = 3'd0;
  localparam round_state_t ST_SPAWN = 3'd1;
  localparam round_state_t ST_WAIT  = 3'd2;
  localparam round_state_t ST_HIT   = 3'd3;
  localparam round_state_t ST_MISS  = 3'd4;
  localparam round_state_t ST_OVER  = 3'd5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_N_MOLES = 16;
  localparam int DEF_SCORE_W = 6;

  // Right-shifting Galois step: the bit shifted out decides whether the
  // tap pattern is folded back into the register.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] shifted;
    shifted = cur >> 1;
    if (cur[0]) begin
      shifted = shifted ^ LFSR_TAPS;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Board-side bundle of the round controller.
//   start, tick, sw        : game inputs (start pulse, timebase strobe, raw switches)
//   LED                    : mole display
//   score_count, miss_count: running game counters
//   game_over, active      : coarse game status
// The master modport drives the inputs (board / bench), the slave modport is
// the controller itself.
interface mole_round_ctrl_if
  import whack_pkg::*;
#(
  parameter int N_MOLES = DEF_N_MOLES,
  parameter int SCORE_W = DEF_SCORE_W
);

  logic               start;
  logic               tick;
  logic [N_MOLES-1:0] sw;
  logic [N_MOLES-1:0] LED;
  logic [SCORE_W-1:0] score_count;
  logic [1:0]         miss_count;
  logic               game_over;
  logic               active;

  modport master (
    output start, tick, sw,
    input  LED, score_count, miss_count, game_over, active
  );

  modport slave (
    input  start, tick, sw,
    output LED, score_count, miss_count, game_over, active
  );

endinterface

// File: rtl/mole_round_ctrl_lfsr.sv
// Free-running 16-bit Galois LFSR used as the mole picker.
//   clk   : system clock
//   reset : asynchronous active-high, reloads SEED
//   state : current register contents, advances every clock
module mole_lfsr
  import whack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  // The register never stops so the pick depends on how long the player took,
  // which is what makes the mole sequence feel random.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEED;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller.
// Picks a pseudo-random mole, lights it for a window of WINDOW_TICKS tick
// pulses, judges switch flips as hit or miss, keeps score and misses, and
// ends the game after MAX_MISSES misses.
//   clk, reset : system clock, asynchronous active-high reset
//   bus.start  : one-clock pulse, starts a game from IDLE or OVER
//   bus.tick   : one-clock timebase strobe for the hit window
//   bus.sw     : raw board switches (asynchronous)
//   bus.LED    : one-hot mole while waiting, all ones when the game is over
//   bus.score_count / bus.miss_count : counters for the current game
//   bus.game_over / bus.active       : status flags
module mole_round_ctrl
  import whack_pkg::*;
#(
  parameter int          N_MOLES      = DEF_N_MOLES,
  parameter int          WINDOW_TICKS = 500,
  parameter int          MAX_MISSES   = 3,
  parameter int          SCORE_W      = DEF_SCORE_W,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  mole_round_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(N_MOLES);
  localparam int TMR_W = $clog2(WINDOW_TICKS + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  round_state_t       state;
  logic [IDX_W-1:0]   target;
  logic [TMR_W-1:0]   timer;
  logic [SCORE_W-1:0] score;
  logic [1:0]         misses;
  logic [N_MOLES-1:0] led_q;

  logic [N_MOLES-1:0] sw_meta;
  logic [N_MOLES-1:0] sw_sync;
  logic [N_MOLES-1:0] sw_prev;
  logic [N_MOLES-1:0] tog;

  logic [15:0]        lfsr_state;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   cand_inc;
  logic [IDX_W-1:0]   pick;
  logic [N_MOLES-1:0] target_mask;
  logic               tog_target;
  logic               tog_wrong;
  logic               unused_lfsr_hi;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  // Only the low index bits pick the mole; the rest just keep the sequence long.
  assign unused_lfsr_hi = ^lfsr_state[15:IDX_W];

  // Switch path: two flops to tame metastability, then an edge detector.
  // tog is registered so each flip produces exactly one clean one-clock pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_prev <= '0;
      tog     <= '0;
    end else begin
      sw_meta <= bus.sw;
      sw_sync <= sw_meta;
      sw_prev <= sw_sync;
      tog     <= sw_sync ^ sw_prev;
    end
  end

  // Mole selection and toggle classification. The candidate is bumped by one
  // when it would light the same mole twice in a row.
  always_comb begin
    cand        = IDX_W'(32'(lfsr_state[IDX_W-1:0]) % N_MOLES);
    cand_inc    = (32'(cand) == N_MOLES - 1) ? '0 : cand + IDX_W'(1);
    pick        = (cand == target) ? cand_inc : cand;
    target_mask = N_MOLES'(1) << target;
    tog_target  = tog[target];
    tog_wrong   = |(tog & ~target_mask);
  end

  // Round state machine. Every state is a registered step; toggles arriving
  // outside WAIT are simply not looked at, and since the edge detector keeps
  // running they cannot show up later in the next window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      target <= '0;
      timer  <= '0;
      score  <= '0;
      misses <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            score  <= '0;
            misses <= '0;
            state  <= ST_SPAWN;
          end
        end
        ST_SPAWN: begin
          target <= pick;
          timer  <= TMR_W'(WINDOW_TICKS - 1);
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tog_target) begin
            state <= ST_HIT;
          end else if (tog_wrong) begin
            state <= ST_MISS;
          end else if (bus.tick) begin
            if (timer == '0) begin
              state <= ST_MISS;
            end else begin
              timer <= timer - TMR_W'(1);
            end
          end
        end
        ST_HIT: begin
          if (score != SCORE_MAX) begin
            score <= score + SCORE_W'(1);
          end
          state <= ST_SPAWN;
        end
        ST_MISS: begin
          misses <= misses + 2'd1;
          if (misses == 2'(MAX_MISSES - 1)) begin
            state <= ST_OVER;
          end else begin
            state <= ST_SPAWN;
          end
        end
        ST_OVER: begin
          if (bus.start) begin
            score  <= '0;
            misses <= '0;
            state  <= ST_SPAWN;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The display is registered from the current state, so it trails the state
  // by one clock: the mole appears the clock after WAIT is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      case (state)
        ST_WAIT: led_q <= target_mask;
        ST_OVER: led_q <= '1;
        default: led_q <= '0;
      endcase
    end
  end

  assign bus.LED         = led_q;
  assign bus.score_count = score;
  assign bus.miss_count  = misses;
  assign bus.game_over   = (state == ST_OVER);
  assign bus.active      = (state == ST_SPAWN) || (state == ST_WAIT) ||
                           (state == ST_HIT)   || (state == ST_MISS);

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl with a 4-tick window and a tick every
// 10 clocks. Expected mole positions come from an independent LFSR model
// clocked alongside the design.
module tb_mole_round_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [15:0] m_lfsr;
  logic [15:0] m_d1;
  logic [15:0] m_d2;
  logic [3:0]  exp_prev;
  logic [3:0]  cur_idx;
  logic [15:0] saved_led;

  mole_round_ctrl_if #(.N_MOLES(16), .SCORE_W(6)) bus ();

  mole_round_ctrl #(
    .N_MOLES      (16),
    .WINDOW_TICKS (4),
    .MAX_MISSES   (3),
    .SCORE_W      (6),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Timebase: one-clock tick every 10 clocks, driven away from the rising edge.
  initial begin
    bus.tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference LFSR with a two-deep history: the mole first seen after edge m
  // was chosen from the value present two clocks earlier.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_d1   <= 16'hACE1;
      m_d2   <= 16'hACE1;
    end else begin
      m_d2   <= m_d1;
      m_d1   <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] flip_mask);
    bus.sw = bus.sw ^ flip_mask;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitLed();
    logic       found;
    logic [3:0] exp_t;
    int         obs_idx;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.LED != 16'h0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("led_appears", 32'(found), 32'd1);
    exp_t = m_d2[3:0];
    if (exp_t == exp_prev) exp_t = exp_t + 4'd1;
    checkOutput("led_onehot", 32'($onehot(bus.LED)), 32'd1);
    checkOutput("led_target", 32'(bus.LED), 32'(16'h1 << exp_t));
    obs_idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.LED[i]) obs_idx = i;
    end
    checkOutput("no_repeat", 32'(obs_idx != 32'(exp_prev)), 32'd1);
    exp_prev = exp_t;
    cur_idx  = exp_t;
  endtask

  task automatic waitMiss(input logic [1:0] exp_miss, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.miss_count == exp_miss) break;
    end
    checkOutput("miss_count", 32'(bus.miss_count), 32'(exp_miss));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_prev  = 4'd0;
    cur_idx   = 4'd0;
    saved_led = 16'h0;
    bus.start = 1'b0;
    bus.sw    = 16'h0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] idle after reset");
    repeat (20) @(negedge clk);
    checkOutput("idle_led",       32'(bus.LED), 32'h0);
    checkOutput("idle_score",     32'(bus.score_count), 32'h0);
    checkOutput("idle_miss",      32'(bus.miss_count), 32'h0);
    checkOutput("idle_game_over", 32'(bus.game_over), 32'h0);
    checkOutput("idle_active",    32'(bus.active), 32'h0);

    $display("[TB] first hit with exact latency");
    pulseStart();
    checkOutput("start_active", 32'(bus.active), 32'h1);
    waitLed();
    repeat (5) @(negedge clk);
    applyStimulus(16'h1 << cur_idx);
    repeat (4) @(negedge clk);
    checkOutput("hit_score_early", 32'(bus.score_count), 32'h0);
    @(negedge clk);
    checkOutput("hit_score", 32'(bus.score_count), 32'h1);
    waitLed();

    $display("[TB] start ignored while playing");
    saved_led = bus.LED;
    pulseStart();
    repeat (2) @(negedge clk);
    checkOutput("start_ignored_led",   32'(bus.LED), 32'(saved_led));
    checkOutput("start_ignored_score", 32'(bus.score_count), 32'h1);

    $display("[TB] target and wrong switch together");
    applyStimulus((16'h1 << cur_idx) | (16'h1 << (cur_idx ^ 4'd1)));
    repeat (5) @(negedge clk);
    checkOutput("combo_score", 32'(bus.score_count), 32'h2);
    checkOutput("combo_miss",  32'(bus.miss_count), 32'h0);
    waitLed();

    $display("[TB] wrong switch");
    applyStimulus(16'h1 << (cur_idx ^ 4'd1));
    waitMiss(2'd1, 10);
    checkOutput("wrong_score", 32'(bus.score_count), 32'h2);
    waitLed();

    $display("[TB] timeouts to game over");
    waitMiss(2'd2, 80);
    waitLed();
    waitMiss(2'd3, 80);
    checkOutput("over_flag",   32'(bus.game_over), 32'h1);
    checkOutput("over_active", 32'(bus.active), 32'h0);
    @(negedge clk);
    checkOutput("over_led",    32'(bus.LED), 32'hFFFF);
    checkOutput("over_score",  32'(bus.score_count), 32'h2);

    $display("[TB] restart, saturate score, long no-repeat run");
    pulseStart();
    checkOutput("restart_score",  32'(bus.score_count), 32'h0);
    checkOutput("restart_miss",   32'(bus.miss_count), 32'h0);
    checkOutput("restart_active", 32'(bus.active), 32'h1);
    for (int r = 0; r < 1000; r++) begin
      waitLed();
      applyStimulus(16'h1 << cur_idx);
      repeat (5) @(negedge clk);
      checkOutput("run_score", 32'(bus.score_count), (r < 62) ? 32'(r + 1) : 32'd63);
    end
    checkOutput("run_miss", 32'(bus.miss_count), 32'h0);

    $display("[TB] asynchronous reset mid-window");
    waitLed();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_led",       32'(bus.LED), 32'h0);
    checkOutput("areset_score",     32'(bus.score_count), 32'h0);
    checkOutput("areset_miss",      32'(bus.miss_count), 32'h0);
    checkOutput("areset_active",    32'(bus.active), 32'h0);
    checkOutput("areset_game_over", 32'(bus.game_over), 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    exp_prev = 4'd0;
    repeat (5) @(negedge clk);
    checkOutput("post_reset_active", 32'(bus.active), 32'h0);
    checkOutput("post_reset_led",    32'(bus.LED), 32'h0);
    pulseStart();
    waitLed();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
